// File: rtl/fp_div_sched_pkg.sv
// fp_div_sched_pkg: shared FSM states and floating-point constants for fp_div_sched
package fp_div_sched_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
  localparam int FP_W = 32;
  localparam logic [FP_W-1:0] QNAN = 32'h7FC00000;
endpackage

// File: rtl/fp_div_sched_rr_arbiter.sv
// rr_arbiter: picks the first asserted request at or after ptr, wrapping circularly
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);
  // scan from farthest to nearest so the nearest hit at or after ptr wins
  always_comb begin
    int j;
    j = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        gnt = N'(1) << j;
        idx = W'(j);
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fp_div_sched.sv
// fp_div_sched: round-robin scheduler sharing one fp_div among N_REQ requesters with timeout
module fp_div_sched
  import fp_div_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int TMO   = 255,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_vld,
  output logic [N_REQ-1:0]      req_rdy,
  input  logic [N_REQ*FP_W-1:0] req_a,
  input  logic [N_REQ*FP_W-1:0] req_b,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [FP_W-1:0]       rsp_c,
  output logic [ID_W-1:0]       rsp_id,
  output logic                  rsp_err,
  output logic                  div_arg_vld,
  input  logic                  div_busy,
  input  logic                  div_res_vld,
  output logic [FP_W-1:0]       div_a,
  output logic [FP_W-1:0]       div_b,
  input  logic [FP_W-1:0]       div_c
);
  localparam int WD_W = $clog2(TMO + 1);

  state_t            r_state, w_next;
  logic [ID_W-1:0]   r_ptr, r_id, w_idx;
  logic [N_REQ-1:0]  w_gnt;
  logic              w_any, w_take, w_tmo;
  logic [FP_W-1:0]   r_a, r_b, r_c;
  logic              r_err;
  logic [WD_W-1:0]   r_wd;

  rr_arbiter #(.N(N_REQ), .W(ID_W)) u_arb (
    .req (req_vld),
    .ptr (r_ptr),
    .gnt (w_gnt),
    .idx (w_idx),
    .any (w_any)
  );

  assign w_take      = w_any && !div_busy;
  assign w_tmo       = r_wd == WD_W'(TMO - 1);
  assign req_rdy     = (r_state == S_IDLE && w_take && !rst) ? w_gnt : '0;
  assign div_arg_vld = r_state == S_ISSUE && !rst;
  assign rsp_vld     = r_state == S_RESP && !rst;
  assign div_a       = r_a;
  assign div_b       = r_b;
  assign rsp_c       = r_c;
  assign rsp_id      = r_id;
  assign rsp_err     = r_err;

  // state register
  always_ff @(posedge clk)
    r_state <= rst ? S_IDLE : w_next;

  // next-state: one issue cycle, wait for result or watchdog, hold response until consumed
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_take ? S_ISSUE : S_IDLE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  w_next = (div_res_vld || w_tmo) ? S_RESP : S_WAIT;
      S_RESP:  w_next = rsp_rdy ? S_IDLE : S_RESP;
      default: w_next = S_IDLE;
    endcase
  end

  // operand latch, watchdog, response capture and round-robin pointer advance
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_c   <= '0;
      r_id  <= '0;
      r_err <= 1'b0;
      r_ptr <= '0;
      r_wd  <= '0;
    end else begin
      if (r_state == S_IDLE && w_take) begin
        r_a  <= req_a[w_idx*FP_W +: FP_W];
        r_b  <= req_b[w_idx*FP_W +: FP_W];
        r_id <= w_idx;
      end
      if (r_state == S_ISSUE)
        r_wd <= '0;
      if (r_state == S_WAIT) begin
        r_wd <= r_wd + 1'b1;
        if (div_res_vld) begin
          r_c   <= div_c;
          r_err <= 1'b0;
        end else if (w_tmo) begin
          r_c   <= QNAN;
          r_err <= 1'b1;
        end
      end
      if (r_state == S_RESP && rsp_rdy)
        r_ptr <= (r_id == ID_W'(N_REQ - 1)) ? '0 : r_id + 1'b1;
    end
  end
endmodule

// File: tb/tb_fp_div_sched.sv
// tb_fp_div_sched: directed self-checking bench with the bench acting as the fp_div stub
module tb_fp_div_sched;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req_vld = '0;
  logic [3:0]   req_rdy;
  logic [127:0] req_a = '0;
  logic [127:0] req_b = '0;
  logic         rsp_vld;
  logic         rsp_rdy = 1'b0;
  logic [31:0]  rsp_c;
  logic [1:0]   rsp_id;
  logic         rsp_err;
  logic         div_arg_vld;
  logic         div_busy = 1'b0;
  logic         div_res_vld = 1'b0;
  logic [31:0]  div_a, div_b;
  logic [31:0]  div_c = '0;
  int n_chk = 0;
  int n_fail = 0;

  fp_div_sched #(.N_REQ(4), .TMO(8)) dut (
    .clk (clk), .rst (rst),
    .req_vld (req_vld), .req_rdy (req_rdy), .req_a (req_a), .req_b (req_b),
    .rsp_vld (rsp_vld), .rsp_rdy (rsp_rdy), .rsp_c (rsp_c), .rsp_id (rsp_id), .rsp_err (rsp_err),
    .div_arg_vld (div_arg_vld), .div_busy (div_busy), .div_res_vld (div_res_vld),
    .div_a (div_a), .div_b (div_b), .div_c (div_c)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    req_vld = 4'b0001;
    tick();
    tick();
    chk("rst_req_rdy", 32'(req_rdy), 0);
    chk("rst_rsp_vld", 32'(rsp_vld), 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    chk("rst_rsp_c", rsp_c, 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_arg_vld", 32'(div_arg_vld), 0);
    chk("rst_div_a", div_a, 0);
    chk("rst_div_b", div_b, 0);

    // 15.0 / 3.0 from requester 0
    req_a[31:0] = 32'h41700000;
    req_b[31:0] = 32'h40400000;
    rst = 1'b0;
    #1;
    chk("div_req_rdy", 32'(req_rdy), 32'h1);
    tick();
    req_vld = '0;
    chk("div_arg_vld", 32'(div_arg_vld), 1);
    chk("div_a", div_a, 32'h41700000);
    chk("div_b", div_b, 32'h40400000);
    tick();
    chk("div_arg_pulse", 32'(div_arg_vld), 0);
    chk("div_wait_rsp", 32'(rsp_vld), 0);
    div_res_vld = 1'b1;
    div_c = 32'h40A00000;
    tick();
    div_res_vld = 1'b0;
    chk("div_rsp_vld", 32'(rsp_vld), 1);
    chk("div_rsp_c", rsp_c, 32'h40A00000);
    chk("div_rsp_id", 32'(rsp_id), 0);
    chk("div_rsp_err", 32'(rsp_err), 0);
    rsp_rdy = 1'b1;
    tick();
    rsp_rdy = 1'b0;
    chk("div_rsp_done", 32'(rsp_vld), 0);

    // all four requesting: grants rotate 0,1,2,3,0 and responses are held while rsp_rdy is low
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_a[32*i +: 32] = 32'h3F800000 + 32'(i);
      req_b[32*i +: 32] = 32'h40000000 + 32'(i);
    end
    req_vld = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("rr_req_rdy", 32'(req_rdy), 32'(1) << (k % 4));
      tick();
      chk("rr_arg_vld", 32'(div_arg_vld), 1);
      chk("rr_div_a", div_a, 32'h3F800000 + 32'(k % 4));
      chk("rr_div_b", div_b, 32'h40000000 + 32'(k % 4));
      tick();
      div_res_vld = 1'b1;
      div_c = 32'h42000000 + 32'(k);
      tick();
      div_res_vld = 1'b0;
      div_c = 32'hDEADBEEF;
      for (int h = 0; h < 5; h++) begin
        chk("hold_rsp_vld", 32'(rsp_vld), 1);
        chk("hold_rsp_c", rsp_c, 32'h42000000 + 32'(k));
        chk("hold_rsp_id", 32'(rsp_id), 32'(k % 4));
        chk("hold_rsp_err", 32'(rsp_err), 0);
        chk("hold_req_rdy", 32'(req_rdy), 0);
        chk("hold_arg_vld", 32'(div_arg_vld), 0);
        tick();
      end
      rsp_rdy = 1'b1;
      #1;
      chk("ack_req_rdy", 32'(req_rdy), 0);
      tick();
      rsp_rdy = 1'b0;
      if (k == 4) req_vld = '0;
      #1;
    end

    // divider never answers: timeout response 9 cycles after issue
    do_reset();
    req_vld = 4'b0001;
    tick();
    req_vld = '0;
    chk("tmo_arg_vld", 32'(div_arg_vld), 1);
    for (int n = 1; n <= 9; n++) begin
      tick();
      chk("tmo_rsp_vld", 32'(rsp_vld), (n == 9) ? 1 : 0);
    end
    chk("tmo_rsp_c", rsp_c, 32'h7FC00000);
    chk("tmo_rsp_err", 32'(rsp_err), 1);
    chk("tmo_rsp_id", 32'(rsp_id), 0);
    div_res_vld = 1'b1;
    div_c = 32'h12345678;
    tick();
    div_res_vld = 1'b0;
    chk("resp_ignore_res", rsp_c, 32'h7FC00000);
    chk("resp_ignore_err", 32'(rsp_err), 1);
    rsp_rdy = 1'b1;
    tick();
    rsp_rdy = 1'b0;

    // reset during WAIT abandons the division; late result ignored; pointer back to 0
    req_vld = 4'b0010;
    #1;
    chk("abort_req_rdy", 32'(req_rdy), 32'h2);
    tick();
    req_vld = '0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    div_res_vld = 1'b1;
    div_c = 32'h40A00000;
    tick();
    div_res_vld = 1'b0;
    for (int n = 0; n < 3; n++) begin
      chk("abort_rsp_vld", 32'(rsp_vld), 0);
      chk("abort_rsp_c", rsp_c, 0);
      tick();
    end
    req_vld = 4'b1111;
    #1;
    chk("abort_next_grant", 32'(req_rdy), 32'h1);
    tick();
    req_vld = '0;
    chk("abort_next_div_a", div_a, 32'h3F800000);

    // divider busy holds off the grant
    do_reset();
    div_busy = 1'b1;
    req_vld = 4'b0010;
    #1;
    for (int n = 0; n < 3; n++) begin
      chk("busy_req_rdy", 32'(req_rdy), 0);
      chk("busy_arg_vld", 32'(div_arg_vld), 0);
      tick();
    end
    div_busy = 1'b0;
    #1;
    chk("busy_release_rdy", 32'(req_rdy), 32'h2);
    tick();
    req_vld = '0;
    chk("busy_arg_vld_on", 32'(div_arg_vld), 1);
    chk("busy_div_a", div_a, 32'h3F800001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fp_div_sched.md
FP_DIV_SCHED -- requirements
Module: fp_div_sched

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one fp_div instance (2..8).
REQ-002 Parameter TMO, default 255: maximum cycles spent in WAIT before a timeout response.
REQ-003 Parameter ID_W, default $clog2(N_REQ): width of the requester index.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 req_vld  in  N_REQ  per-requester operation request.
REQ-008 req_rdy  out  N_REQ  per-requester accept; at most one bit high.
REQ-009 req_a  in  N_REQ*32  per-requester IEEE-754 single dividend; slice i = bits [32i+31:32i].
REQ-010 req_b  in  N_REQ*32  per-requester divisor, same slicing.
REQ-011 rsp_vld  out  1  response valid.
REQ-012 rsp_rdy  in  1  response consumed.
REQ-013 rsp_c  out  32  quotient.
REQ-014 rsp_id  out  ID_W  index of the requester owning the response.
REQ-015 rsp_err  out  1  response produced by timeout; rsp_c = 0x7FC00000.
REQ-016 div_arg_vld  out  1  to fp_div arg_vld.
REQ-017 div_busy  in  1  from fp_div busy.
REQ-018 div_res_vld  in  1  from fp_div res_vld.
REQ-019 div_a, div_b  out  32  to fp_div a, b.
REQ-020 div_c  in  32  from fp_div c.

Function
REQ-021 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-022 IDLE: if any req_vld and div_busy=0, grant the first asserted req_vld at or after rr_ptr (circular); req_rdy[grant]=1 that cycle; latch req_a/req_b slice and grant index; next state ISSUE.
REQ-023 IDLE with div_busy=1 or no req_vld: req_rdy all 0, remain IDLE.
REQ-024 ISSUE: div_arg_vld=1 for exactly one cycle with div_a/div_b from the latched operands; next state WAIT; watchdog cleared to 0.
REQ-025 div_a/div_b hold the latched operands from ISSUE until the next grant.
REQ-026 WAIT: on div_res_vld=1 latch div_c into rsp_c, rsp_err=0, next state RESP; div_res_vld outside WAIT is ignored.
REQ-027 WAIT: watchdog increments each cycle; on reaching TMO without div_res_vld, rsp_c=0x7FC00000, rsp_err=1, next state RESP.
REQ-028 RESP: rsp_vld=1; rsp_c, rsp_id, rsp_err stable until rsp_rdy=1; on rsp_rdy, rr_ptr = (grant+1) mod N_REQ, next state IDLE.
REQ-029 Minimum request-to-request spacing is one IDLE cycle after RESP; new requests are not accepted in the rsp_rdy cycle.
REQ-030 req_vld deasserted by a non-granted requester has no effect; requests are never dropped once granted.
REQ-031 A single requester with continuous req_vld is served back-to-back; with all N_REQ asserted, grants rotate 0,1,...,N_REQ-1,0.

Reset
REQ-032 rst forces state IDLE, rr_ptr=0, watchdog=0 on the next edge, from any state.
REQ-033 During and after reset: req_rdy=0, rsp_vld=0, rsp_err=0, rsp_c=0, rsp_id=0, div_arg_vld=0, div_a=div_b=0.
REQ-034 A division in flight at reset is abandoned; its later div_res_vld is ignored (state IDLE).

Structure
REQ-035 Package fp_div_sched_pkg holds the state enum, FP_W=32, and the QNAN constant 0x7FC00000.
REQ-036 Round-robin grant logic is a sub-module rr_arbiter (inputs req, ptr; outputs one-hot grant, grant index, any).
REQ-037 fp_div is instantiated outside this block; only its ports are driven.

Verification
REQ-038 Req0 a=0x41700000, b=0x40400000 (15.0/3.0) -> one div_arg_vld pulse, rsp_vld with rsp_c=0x40A00000, rsp_id=0, rsp_err=0.
REQ-039 All four req_vld held high -> grants in order 0,1,2,3,0; each rsp_id matches.
REQ-040 Stub divider never asserts div_res_vld, TMO=8 -> rsp_vld 9 cycles after ISSUE, rsp_c=0x7FC00000, rsp_err=1.
REQ-041 rsp_rdy held low 5 cycles in RESP -> rsp outputs stable, req_rdy remains 0, no div_arg_vld.
REQ-042 rst pulsed during WAIT, div_res_vld arriving 2 cycles later -> rsp_vld stays 0, state IDLE, next grant to req0.
REQ-043 div_busy=1 in IDLE with req_vld=0b0010 -> no grant until div_busy drops, then req_rdy=0b0010.
